// File: rtl/wallace_mul_arbiter_if.sv
// Request/result bus of the shared Wallace multiplier arbiter.
// The arbiter uses the slave view; clients and consumer use the master view.
interface wallace_mul_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [IDW-1:0]       res_id;
  logic [31:0]          res_p;
  logic                 busy;
  logic [15:0]          ops_cnt;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_p, busy, ops_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_p, busy, ops_cnt
  );
endinterface

// File: rtl/wallace_mul_arbiter.sv
// Round-robin arbiter sharing one combinational 16x16 signed Wallace multiplier.
// Define WALLACE_ARB_PIPE_EN to add a registered operand stage in front of the multiplier.

module wallace_csa32 (
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  input  logic [31:0] i_z,
  output logic [31:0] o_s,
  output logic [31:0] o_c
);
  assign o_s = i_x ^ i_y ^ i_z;
  assign o_c = ((i_x & i_y) | (i_x & i_z) | (i_y & i_z)) << 1;
endmodule

module wallace_mul16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  logic [31:0] w_a_ext;
  logic [31:0] w_l0 [17];
  logic [31:0] w_l1 [12];
  logic [31:0] w_l2 [8];
  logic [31:0] w_l3 [6];
  logic [31:0] w_l4 [4];
  logic [31:0] w_l5 [3];
  logic [31:0] w_l6 [2];

  assign w_a_ext = {{16{i_a[15]}}, i_a};

  // The multiplier's sign bit weighs -2^15: that row is inverted and its +1 rides in row 16.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_pp
      assign w_l0[gi] = i_b[gi] ? (w_a_ext << gi) : 32'd0;
    end
  endgenerate
  assign w_l0[15] = i_b[15] ? ~(w_a_ext << 15) : 32'd0;
  assign w_l0[16] = {31'd0, i_b[15]};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_lv1
      wallace_csa32 u_csa (.i_x(w_l0[3*gi]), .i_y(w_l0[3*gi+1]), .i_z(w_l0[3*gi+2]),
                           .o_s(w_l1[2*gi]), .o_c(w_l1[2*gi+1]));
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_lv2
      wallace_csa32 u_csa (.i_x(w_l1[3*gi]), .i_y(w_l1[3*gi+1]), .i_z(w_l1[3*gi+2]),
                           .o_s(w_l2[2*gi]), .o_c(w_l2[2*gi+1]));
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_lv3
      wallace_csa32 u_csa (.i_x(w_l2[3*gi]), .i_y(w_l2[3*gi+1]), .i_z(w_l2[3*gi+2]),
                           .o_s(w_l3[2*gi]), .o_c(w_l3[2*gi+1]));
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_lv4
      wallace_csa32 u_csa (.i_x(w_l3[3*gi]), .i_y(w_l3[3*gi+1]), .i_z(w_l3[3*gi+2]),
                           .o_s(w_l4[2*gi]), .o_c(w_l4[2*gi+1]));
    end
  endgenerate

  assign w_l1[10] = w_l0[15];
  assign w_l1[11] = w_l0[16];
  assign w_l3[4]  = w_l2[6];
  assign w_l3[5]  = w_l2[7];

  wallace_csa32 u_csa5 (.i_x(w_l4[0]), .i_y(w_l4[1]), .i_z(w_l4[2]),
                        .o_s(w_l5[0]), .o_c(w_l5[1]));
  assign w_l5[2] = w_l4[3];

  wallace_csa32 u_csa6 (.i_x(w_l5[0]), .i_y(w_l5[1]), .i_z(w_l5[2]),
                        .o_s(w_l6[0]), .o_c(w_l6[1]));

  assign o_p = w_l6[0] + w_l6[1];
endmodule

module wallace_mul_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wallace_mul_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_gidx;
  logic [IDW-1:0] w_ptr_next;
  logic           w_gany;
  logic           w_out_free;
  logic           w_entry_free;
  logic           w_take;
  logic [15:0]    w_req_a [NREQ];
  logic [15:0]    w_req_b [NREQ];
  logic [15:0]    w_sel_a;
  logic [15:0]    w_sel_b;
  logic [15:0]    w_mul_a;
  logic [15:0]    w_mul_b;
  logic [31:0]    w_mul_p;

  logic           r_res_valid;
  logic [IDW-1:0] r_res_id;
  logic [31:0]    r_res_p;
  logic [15:0]    r_ops_cnt;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_req_a[gi] = bus.req_a[16*gi +: 16];
      assign w_req_b[gi] = bus.req_b[16*gi +: 16];
    end
  endgenerate

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    int v_idx;
    w_gany = 1'b0;
    w_gidx = '0;
    v_idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_gany && bus.req_valid[IDW'(v_idx)]) begin
        w_gany = 1'b1;
        w_gidx = IDW'(v_idx);
      end
    end
  end

  always_comb begin
    int v_nxt;
    v_nxt = int'(w_gidx) + 1;
    if (v_nxt >= NREQ) v_nxt = 0;
    w_ptr_next = IDW'(v_nxt);
  end

  assign w_out_free = !r_res_valid || bus.res_ready;
  assign w_take     = !rst && w_gany && w_entry_free;
  assign w_sel_a    = w_req_a[w_gidx];
  assign w_sel_b    = w_req_b[w_gidx];

  always_comb begin
    bus.req_ready = '0;
    if (w_take) bus.req_ready[w_gidx] = 1'b1;
  end

  wallace_mul16 u_mul (.i_a(w_mul_a), .i_b(w_mul_b), .o_p(w_mul_p));

`ifdef WALLACE_ARB_PIPE_EN
  logic           r_s1_valid;
  logic [15:0]    r_s1_a;
  logic [15:0]    r_s1_b;
  logic [IDW-1:0] r_s1_id;
  logic           w_s1_adv;

  assign w_entry_free = !r_s1_valid || w_out_free;
  assign w_s1_adv     = r_s1_valid && w_out_free;
  assign w_mul_a      = r_s1_a;
  assign w_mul_b      = r_s1_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_id     <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_p     <= '0;
    end else begin
      if (w_take) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= w_sel_a;
        r_s1_b     <= w_sel_b;
        r_s1_id    <= w_gidx;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s1_adv) begin
        r_res_valid <= 1'b1;
        r_res_p     <= w_mul_p;
        r_res_id    <= r_s1_id;
      end else if (bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.busy = r_s1_valid || r_res_valid;
`else
  assign w_entry_free = w_out_free;
  assign w_mul_a      = w_sel_a;
  assign w_mul_b      = w_sel_b;

  // A load always wins over a drain, so the slot refills in the same cycle it empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_p     <= '0;
    end else if (w_take) begin
      r_res_valid <= 1'b1;
      r_res_p     <= w_mul_p;
      r_res_id    <= w_gidx;
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.busy = r_res_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_ops_cnt <= '0;
    end else begin
      if (w_take) r_ptr <= w_ptr_next;
      if (r_res_valid && bus.res_ready) r_ops_cnt <= r_ops_cnt + 16'd1;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_p     = r_res_p;
  assign bus.ops_cnt   = r_ops_cnt;
endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Directed bench for wallace_mul_arbiter: vector table plus arbitration,
// backpressure, reset, streaming and counter-wrap sequences.
module tb_wallace_mul_arbiter;
  localparam int NREQ = 4;
`ifdef WALLACE_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wallace_mul_arbiter_if #(.NREQ(NREQ)) bus ();
  wallace_mul_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]  id;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] p;
  } exp_t;

  vec_t        vecs [9];
  exp_t        sb [$];
  logic [1:0]  grants [$];
  logic [31:0] cur_p [NREQ];
  logic [15:0] exp_ops;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_drain;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] p);
    bus.req_a[16*id +: 16] = a;
    bus.req_b[16*id +: 16] = b;
    cur_p[id] = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: score any drain, log any grant, then optionally drop granted requests.
  task automatic step(input bit drop);
    logic [NREQ-1:0] hs;
    #1;
    hs = bus.req_valid & bus.req_ready;
    if (bus.res_valid && bus.res_ready) begin
      n_drain++;
      exp_ops++;
      $display("result id=%0d p=0x%08h", bus.res_id, bus.res_p);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL drain: got id %0d p 0x%08h, expected no result", bus.res_id, bus.res_p);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("drain_id", 32'(bus.res_id), 32'(e.id));
        chk("drain_p", bus.res_p, e.p);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        exp_t n;
        n.id = 2'(i);
        n.p  = cur_p[i];
        sb.push_back(n);
        grants.push_back(2'(i));
      end
    end
    @(posedge clk);
    #1;
    if (drop) bus.req_valid = bus.req_valid & ~hs;
  endtask

  initial begin
    logic [3:0]  mask;
    logic [15:0] base_ops;
    int          cyc;
    int          k;

    vecs[0] = '{2'd0, 16'h0003, 16'hFFFB, 32'hFFFF_FFF1};
    vecs[1] = '{2'd1, 16'h8000, 16'h8000, 32'h4000_0000};
    vecs[2] = '{2'd2, 16'h8000, 16'h0001, 32'hFFFF_8000};
    vecs[3] = '{2'd0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
    vecs[4] = '{2'd1, 16'hFFFF, 16'h0000, 32'h0000_0000};
    vecs[5] = '{2'd2, 16'h1234, 16'h0010, 32'h0001_2340};
    vecs[6] = '{2'd0, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
    vecs[7] = '{2'd1, 16'h7FFF, 16'h8000, 32'hC000_8000};
    vecs[8] = '{2'd3, 16'hFF9C, 16'h00C8, 32'hFFFF_B1E0};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    exp_ops       = '0;
    n_drain       = 0;

    // Reset state, and grants held off while rst is high
    tick();
    tick();
    bus.req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_res_p", bus.res_p, 32'h0);
    chk("rst_res_id", 32'(bus.res_id), 32'h0);
    chk("rst_ops_cnt", 32'(bus.ops_cnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    // Single-op vector table
    for (int v = 0; v < 9; v++) begin
      set_req(int'(vecs[v].id), vecs[v].a, vecs[v].b, vecs[v].p);
      mask = 4'b0001 << vecs[v].id;
      bus.req_valid = mask;
      #1;
      chk("vec_req_ready", 32'(bus.req_ready), 32'(mask));
      tick();
      bus.req_valid = '0;
      repeat (LAT - 1) tick();
      chk("vec_res_valid", 32'(bus.res_valid), 32'h1);
      chk("vec_res_p", bus.res_p, vecs[v].p);
      chk("vec_res_id", 32'(bus.res_id), 32'(vecs[v].id));
      $display("vec %0d: id=%0d a=0x%04h b=0x%04h p=0x%08h", v, bus.res_id, vecs[v].a,
               vecs[v].b, bus.res_p);
      exp_ops++;
      tick();
      chk("vec_ops_cnt", 32'(bus.ops_cnt), 32'(exp_ops));
      chk("vec_res_drained", 32'(bus.res_valid), 32'h0);
    end

    // Fairness: all four requesters continuously valid
    set_req(0, 16'd2, 16'd3, 32'd6);
    set_req(1, 16'hFFFE, 16'd5, 32'hFFFF_FFF6);
    set_req(2, 16'd100, 16'd100, 32'd10000);
    set_req(3, 16'h8000, 16'hFFFF, 32'h0000_8000);
    grants.delete();
    sb.delete();
    n_drain = 0;
    bus.req_valid = 4'hF;
    for (cyc = 0; cyc < 40 && grants.size() < 8; cyc++) step(1'b0);
    bus.req_valid = '0;
    chk("fair_grants", 32'(grants.size()), 32'd8);
    chk("fair_cycles", 32'(cyc), 32'd8);
    for (int i = 0; i < grants.size() && i < 8; i++)
      chk("fair_order", 32'(grants[i]), 32'(i % 4));
    repeat (LAT + 1) step(1'b1);
    chk("fair_drains", 32'(n_drain), 32'd8);
    chk("fair_ops_cnt", 32'(bus.ops_cnt), 32'(exp_ops));
    chk("fair_busy", 32'(bus.busy), 32'h0);

    // Backpressure: results held while res_ready is low
    bus.res_ready = 1'b0;
    set_req(0, 16'd11, 16'd13, 32'd143);
    set_req(1, 16'hFFF6, 16'hFFF6, 32'd100);
    set_req(3, 16'h0100, 16'h0100, 32'h0001_0000);
    grants.delete();
    n_drain = 0;
    bus.req_valid = 4'b1011;
    repeat (LAT) step(1'b1);
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
      chk("bp_res_valid", 32'(bus.res_valid), 32'h1);
      chk("bp_res_id", 32'(bus.res_id), 32'h0);
      chk("bp_res_p", bus.res_p, 32'd143);
      tick();
    end
    chk("bp_accepted", 32'(grants.size()), 32'(LAT));
    chk("bp_ops_hold", 32'(bus.ops_cnt), 32'(exp_ops));
    bus.res_ready = 1'b1;
    repeat (8) step(1'b1);
    chk("bp_drains", 32'(n_drain), 32'd3);
    chk("bp_grants", 32'(grants.size()), 32'd3);
    for (int i = 0; i < grants.size() && i < 3; i++)
      chk("bp_order", 32'(grants[i]), (i == 2) ? 32'd3 : 32'(i));
    chk("bp_ops_cnt", 32'(bus.ops_cnt), 32'(exp_ops));

    // Reset with a result pending; pointer left at 3 beforehand
    bus.res_ready = 1'b0;
    set_req(2, 16'd9, 16'd9, 32'd81);
    bus.req_valid = 4'b0100;
    repeat (LAT) step(1'b1);
    chk("mid_pending", 32'(bus.res_valid), 32'h1);
    set_req(1, 16'd5, 16'hFFF9, 32'hFFFF_FFDD);
    set_req(3, 16'd1, 16'd1, 32'd1);
    bus.req_valid = 4'b1010;
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    chk("mid_res_valid", 32'(bus.res_valid), 32'h0);
    chk("mid_busy", 32'(bus.busy), 32'h0);
    chk("mid_ops_cnt", 32'(bus.ops_cnt), 32'h0);
    rst = 1'b0;
    sb.delete();
    grants.delete();
    exp_ops = '0;
    n_drain = 0;
    bus.res_ready = 1'b1;
    #1;
    chk("mid_first_grant", 32'(bus.req_ready), 32'b0010);
    repeat (LAT + 3) step(1'b1);
    chk("mid_drains", 32'(n_drain), 32'd2);
    chk("mid_ops_after", 32'(bus.ops_cnt), 32'd2);

    // Back-to-back stream from requester 2
    base_ops = exp_ops;
    grants.delete();
    n_drain = 0;
    k = 0;
    for (int c = 0; c < 16 + LAT; c++) begin
      if (k < 16) begin
        logic [15:0] a, b;
        logic signed [31:0] sa, sbv;
        a   = 16'(k * 1000 - 7000);
        b   = 16'(3 - 5 * k);
        sa  = $signed(a);
        sbv = $signed(b);
        set_req(2, a, b, sa * sbv);
        bus.req_valid = 4'b0100;
      end else begin
        bus.req_valid = '0;
      end
      step(1'b0);
      k = grants.size();
    end
    bus.req_valid = '0;
    chk("b2b_grants", 32'(grants.size()), 32'd16);
    chk("b2b_drains", 32'(n_drain), 32'd16);
    chk("b2b_ops_cnt", 32'(bus.ops_cnt), 32'(base_ops + 16'd16));

    // Counter wrap from 0xFFFF
    force dut.r_ops_cnt = 16'hFFFF;
    tick();
    release dut.r_ops_cnt;
    #1;
    chk("wrap_preload", 32'(bus.ops_cnt), 32'h0000_FFFF);
    exp_ops = 16'hFFFF;
    sb.delete();
    set_req(0, 16'd2, 16'd2, 32'd4);
    bus.req_valid = 4'b0001;
    repeat (LAT + 2) step(1'b1);
    chk("wrap_ops_cnt", 32'(bus.ops_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
